exec_stage: RTL and testbench
=============================

# exec_stage

Registered execute stage of the 16-bit pipeline, between the ID/EX operand latch and the EX/MEM boundary. Computes one ALU/shift result per accepted instruction: saturating add/sub, XOR, byte reduction, SLL/SRA/ROR through the existing 16-bit barrel shifter, and nibble-parallel saturating add. Holds the architectural Z/V/N flag register and presents a registered EX/MEM result with valid, stall and flush control.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold stage; no capture, no flag update
- flush  input  1  insert bubble at next edge; overrides stall
- in_valid  input  1  op_a/op_b/opcode/imm/dst_reg hold a real instruction
- opcode  input  4  0000 ADD, 0001 SUB, 0010 XOR, 0011 RED, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB; 1xxx treated as pass-through (result = op_a, no flag update)
- op_a  input  16  first operand, shift source
- op_b  input  16  second operand
- imm  input  4  shift/rotate amount 0..15
- dst_reg  input  4  destination register index, carried through
- out_valid  output  1  EX/MEM slot holds a real result
- out_result  output  16  registered result
- out_dst  output  4  registered dst_reg
- flag_z  output  1  zero flag
- flag_v  output  1  overflow flag
- flag_n  output  1  negative flag

## Operation
- ADD/SUB: 16-bit two's-complement with saturation; positive overflow -> 0x7FFF, negative overflow -> 0x8000. Updates Z (result==0), V (saturation occurred), N (result[15]).
- XOR: op_a ^ op_b; updates Z only.
- RED: signed sum of the four bytes op_a[15:8], op_a[7:0], op_b[15:8], op_b[7:0], computed at 10 bits, sign-extended to 16; no flag update.
- SLL/SRA: shifter with Shift_In=op_a, Shift_Val=imm, Mode=0 (SLL) / 1 (SRA); updates Z only.
- ROR: rotate op_a right by imm, built from two barrel-shifter passes (logical right by imm OR left by 16-imm); imm=0 -> op_a unchanged; updates Z only.
- PADDSB: four independent 4-bit signed adds, each saturating to [-8, 7] (0x7 / 0x8); no flag update.
- Flags written only when the instruction is captured (in_valid=1, stall=0, flush=0) and the opcode updates them; non-updated flags keep prior value.
- Pass-through/bubble (in_valid=0) never changes flags.

## Timing
- Reset: out_valid=0, out_result=0x0000, out_dst=0, flag_z=flag_v=flag_n=0; dominates stall and flush.
- Latency: one cycle; result and flags visible the cycle after capture edge.
- Capture edge (stall=0, flush=0): out_valid<=in_valid, out_result/out_dst<=computed values; flags per Operation.
- stall=1, flush=0: all outputs and flags hold.
- flush=1 (any stall): out_valid<=0, out_result<=0, out_dst<=0; flags hold.
- Back-to-back instructions: flags from cycle N's capture apply for cycle N+1; no forwarding inside this block.
- Combinational path: operand inputs -> shifter/adder -> output register; no input-to-output combinational path.

## Configuration
- EXEC_ROR_EN defined: ROR (0110) implemented as above.
- EXEC_ROR_EN undefined: 0110 behaves as pass-through (result = op_a, no flag update); second shifter pass not instantiated.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1, ADD 1+1 -> out_valid=0, out_result=0x0000, all flags 0; first capture after release gives 0x0002, Z=0 V=0 N=0.
- Saturation: ADD 0x7FFF+0x0001 -> 0x7FFF, V=1 N=0; SUB 0x8000-0x0001 -> 0x8000, V=1 N=1; XOR 0x00FF^0x00FF next -> 0x0000, Z=1, V=1 N=1 retained.
- Shifts: op_a=0x8001 imm=1: SLL -> 0x0002, SRA -> 0xC000, ROR -> 0xC000 (with EXEC_ROR_EN); ROR imm=0 -> 0x8001; ROR without macro -> 0x8001, flags unchanged.
- RED/PADDSB: RED op_a=0x7F7F op_b=0x7F7F -> 0x01FC; PADDSB 0x7788+0x1188 -> 0x7788 (7+1=7, 7+1=7, -8+-8=-8, -8+-8=-8); flags unchanged from prior.
- Stall/flush: capture SUB 5-5 (Z=1), then stall 3 cycles with ADD 1+2 on inputs -> outputs and Z hold; assert stall+flush together -> out_valid=0, result 0, Z still 1.
- Bubble: in_valid=0 with XOR 0x1234^0x1234 -> out_valid=0, Z unchanged.

Source files
------------

// File: rtl/exec_stage.sv
// Registered execute stage of the 16-bit pipeline, holding the Z/V/N flags and the EX/MEM slot.
// Defining EXEC_ROR_EN enables ROR (0110); otherwise 0110 is a pass-through.

module barrel_shifter16 (
    input  logic [15:0] Shift_In,
    input  logic [3:0]  Shift_Val,
    input  logic [1:0]  Mode,
    output logic [15:0] Shift_Out
);
    // Mode 0 = SLL, 1 = SRA, 2/3 = logical right (used by the rotate path)
    logic        left;
    logic        fill;
    logic [15:0] st1, st2, st4;

    always_comb begin
        left = (Mode == 2'd0);
        fill = (Mode == 2'd1) ? Shift_In[15] : 1'b0;
        st1 = Shift_Val[0] ? (left ? {Shift_In[14:0], 1'b0} : {fill, Shift_In[15:1]}) : Shift_In;
        st2 = Shift_Val[1] ? (left ? {st1[13:0], 2'b0} : {{2{fill}}, st1[15:2]}) : st1;
        st4 = Shift_Val[2] ? (left ? {st2[11:0], 4'b0} : {{4{fill}}, st2[15:4]}) : st2;
        Shift_Out = Shift_Val[3] ? (left ? {st4[7:0], 8'b0} : {{8{fill}}, st4[15:8]}) : st4;
    end
endmodule

module exec_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [3:0]  opcode,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic [3:0]  imm,
    input  logic [3:0]  dst_reg,
    output logic        out_valid,
    output logic [15:0] out_result,
    output logic [3:0]  out_dst,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_n
);
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

    logic [16:0] add_w, sub_w;
    logic        add_ovf, sub_ovf;
    logic [9:0]  red_sum;
    logic [15:0] padd_res;
    logic [4:0]  nib_sum;
    logic [3:0]  shift_amt;
    logic [1:0]  shift_mode;
    logic [15:0] shift_main;
    logic [15:0] result;
    logic        upd_z, upd_vn, ovf;

    // One extra sign bit: overflow shows up as bits 16 and 15 disagreeing
    assign add_w   = {op_a[15], op_a} + {op_b[15], op_b};
    assign sub_w   = {op_a[15], op_a} - {op_b[15], op_b};
    assign add_ovf = add_w[16] ^ add_w[15];
    assign sub_ovf = sub_w[16] ^ sub_w[15];

    assign red_sum = {{2{op_a[15]}}, op_a[15:8]} + {{2{op_a[7]}}, op_a[7:0]}
                   + {{2{op_b[15]}}, op_b[15:8]} + {{2{op_b[7]}}, op_b[7:0]};

    always_comb begin
        padd_res = 16'h0000;
        nib_sum  = 5'b0;
        for (int i = 0; i < 4; i++) begin
            nib_sum = {op_a[4*i+3], op_a[4*i +: 4]} + {op_b[4*i+3], op_b[4*i +: 4]};
            if (nib_sum[4] ^ nib_sum[3])
                padd_res[4*i +: 4] = nib_sum[4] ? 4'h8 : 4'h7;
            else
                padd_res[4*i +: 4] = nib_sum[3:0];
        end
    end

`ifdef EXEC_ROR_EN
    // Rotate = (op_a << 16-imm) | (op_a >> imm); imm=0 wraps to a zero left shift
    logic [15:0] shift_ror;
    assign shift_amt  = (opcode == OP_ROR) ? (4'd0 - imm) : imm;
    barrel_shifter16 u_ror_pass (
        .Shift_In  (op_a),
        .Shift_Val (imm),
        .Mode      (2'd2),
        .Shift_Out (shift_ror)
    );
`else
    assign shift_amt  = imm;
`endif
    assign shift_mode = (opcode == OP_SRA) ? 2'd1 : 2'd0;

    barrel_shifter16 u_main_pass (
        .Shift_In  (op_a),
        .Shift_Val (shift_amt),
        .Mode      (shift_mode),
        .Shift_Out (shift_main)
    );

    always_comb begin
        result = op_a;
        upd_z  = 1'b0;
        upd_vn = 1'b0;
        ovf    = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = add_ovf ? (add_w[16] ? 16'h8000 : 16'h7FFF) : add_w[15:0];
                ovf    = add_ovf;
                upd_z  = 1'b1;
                upd_vn = 1'b1;
            end
            OP_SUB: begin
                result = sub_ovf ? (sub_w[16] ? 16'h8000 : 16'h7FFF) : sub_w[15:0];
                ovf    = sub_ovf;
                upd_z  = 1'b1;
                upd_vn = 1'b1;
            end
            OP_XOR: begin
                result = op_a ^ op_b;
                upd_z  = 1'b1;
            end
            OP_RED:    result = {{6{red_sum[9]}}, red_sum};
            OP_SLL, OP_SRA: begin
                result = shift_main;
                upd_z  = 1'b1;
            end
`ifdef EXEC_ROR_EN
            OP_ROR: begin
                result = shift_main | shift_ror;
                upd_z  = 1'b1;
            end
`endif
            OP_PADDSB: result = padd_res;
            default:   result = op_a;
        endcase
    end

    // Flush beats stall; flags only move on a captured real instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= 16'h0000;
            out_dst    <= 4'h0;
            flag_z     <= 1'b0;
            flag_v     <= 1'b0;
            flag_n     <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_result <= 16'h0000;
            out_dst    <= 4'h0;
        end else if (!stall) begin
            out_valid  <= in_valid;
            out_result <= result;
            out_dst    <= dst_reg;
            if (in_valid) begin
                if (upd_z)
                    flag_z <= (result == 16'h0000);
                if (upd_vn) begin
                    flag_v <= ovf;
                    flag_n <= result[15];
                end
            end
        end
    end
endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed test-plan steps, then random steps
// checked against an arithmetic reference model of the execute stage.

module tb_exec_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [3:0]  opcode, imm, dst_reg;
    logic [15:0] op_a, op_b;
    logic        out_valid, flag_z, flag_v, flag_n;
    logic [15:0] out_result;
    logic [3:0]  out_dst;

    int total  = 0;
    int passes = 0;
    int fails  = 0;

    logic        m_valid, m_z, m_v, m_n;
    logic [15:0] m_res;
    logic [3:0]  m_dst;

    exec_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .opcode     (opcode),
        .op_a       (op_a),
        .op_b       (op_b),
        .imm        (imm),
        .dst_reg    (dst_reg),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_dst    (out_dst),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .flag_n     (flag_n)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    // Reference: result plus which flags the opcode writes
    function automatic void ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] sh, output logic [15:0] r,
                                   output logic wz, output logic wvn, output logic vf);
        shortint sa, sb;
        int      s, na, nb;
        byte     b0, b1, b2, b3;
        logic [31:0] dbl;
        sa = a; sb = b;
        wz = 1'b0; wvn = 1'b0; vf = 1'b0; r = a;
        case (op)
            4'd0, 4'd1: begin
                s  = (op == 4'd0) ? int'(sa) + int'(sb) : int'(sa) - int'(sb);
                vf = (s > 32767) || (s < -32768);
                s  = clamp(s, -32768, 32767);
                r  = s[15:0];
                wz = 1'b1; wvn = 1'b1;
            end
            4'd2: begin r = a ^ b; wz = 1'b1; end
            4'd3: begin
                b0 = a[15:8]; b1 = a[7:0]; b2 = b[15:8]; b3 = b[7:0];
                s  = int'(b0) + int'(b1) + int'(b2) + int'(b3);
                r  = s[15:0];
            end
            4'd4: begin r = a << sh; wz = 1'b1; end
            4'd5: begin r = sa >>> sh; wz = 1'b1; end
`ifdef EXEC_ROR_EN
            4'd6: begin dbl = {a, a} >> sh; r = dbl[15:0]; wz = 1'b1; end
`endif
            4'd7: begin
                for (int i = 0; i < 4; i++) begin
                    na = int'(a[4*i +: 4]); nb = int'(b[4*i +: 4]);
                    if (na > 7) na -= 16;
                    if (nb > 7) nb -= 16;
                    s = clamp(na + nb, -8, 7);
                    r[4*i +: 4] = s[3:0];
                end
            end
            default: r = a;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model across the edge, then compare everything
    task automatic apply_stimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] sh, input logic [3:0] dst,
                                  input logic v, input logic st, input logic fl);
        logic [15:0] r;
        logic        wz, wvn, vf;
        opcode = op; op_a = a; op_b = b; imm = sh; dst_reg = dst;
        in_valid = v; stall = st; flush = fl;
        ref_op(op, a, b, sh, r, wz, wvn, vf);
        if (rst) begin
            m_valid = 1'b0; m_res = 16'h0; m_dst = 4'h0;
            m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
        end else if (fl) begin
            m_valid = 1'b0; m_res = 16'h0; m_dst = 4'h0;
        end else if (!st) begin
            m_valid = v; m_res = r; m_dst = dst;
            if (v && wz) m_z = (r == 16'h0);
            if (v && wvn) begin m_v = vf; m_n = r[15]; end
        end
        @(posedge clk);
        #1;
        check_output("out_valid", {15'b0, out_valid}, {15'b0, m_valid});
        check_output("out_result", out_result, m_res);
        check_output("out_dst", {12'b0, out_dst}, {12'b0, m_dst});
        check_output("flag_z", {15'b0, flag_z}, {15'b0, m_z});
        check_output("flag_v", {15'b0, flag_v}, {15'b0, m_v});
        check_output("flag_n", {15'b0, flag_n}, {15'b0, m_n});
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus(4'd0, 16'h0001, 16'h0001, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
        apply_stimulus(4'd0, 16'h0001, 16'h0001, 4'd0, 4'd3, 1'b1, 1'b1, 1'b1);
        check_output("reset_result", out_result, 16'h0000);
        rst = 1'b0;
        apply_stimulus(4'd0, 16'h0001, 16'h0001, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
        check_output("first_add", out_result, 16'h0002);

        apply_stimulus(4'd0, 16'h7FFF, 16'h0001, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        check_output("add_sat", out_result, 16'h7FFF);
        check_output("add_sat_v", {15'b0, flag_v}, 16'h0001);
        apply_stimulus(4'd1, 16'h8000, 16'h0001, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
        check_output("sub_sat", out_result, 16'h8000);
        check_output("sub_sat_n", {15'b0, flag_n}, 16'h0001);
        apply_stimulus(4'd2, 16'h00FF, 16'h00FF, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0);
        check_output("xor_keeps_vn", {13'b0, flag_z, flag_v, flag_n}, 16'h0007);

        apply_stimulus(4'd4, 16'h8001, 16'h0000, 4'd1, 4'd5, 1'b1, 1'b0, 1'b0);
        check_output("sll", out_result, 16'h0002);
        apply_stimulus(4'd5, 16'h8001, 16'h0000, 4'd1, 4'd5, 1'b1, 1'b0, 1'b0);
        check_output("sra", out_result, 16'hC000);
        apply_stimulus(4'd6, 16'h8001, 16'h0000, 4'd1, 4'd5, 1'b1, 1'b0, 1'b0);
`ifdef EXEC_ROR_EN
        check_output("ror1", out_result, 16'hC000);
`else
        check_output("ror_passthru", out_result, 16'h8001);
`endif
        apply_stimulus(4'd6, 16'h8001, 16'h0000, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0);
        check_output("ror0", out_result, 16'h8001);

        apply_stimulus(4'd3, 16'h7F7F, 16'h7F7F, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0);
        check_output("red", out_result, 16'h01FC);
        apply_stimulus(4'd7, 16'h7788, 16'h1188, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0);
        check_output("paddsb", out_result, 16'h7788);

        apply_stimulus(4'd1, 16'h0005, 16'h0005, 4'd0, 4'd8, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            apply_stimulus(4'd0, 16'h0001, 16'h0002, 4'd0, 4'd9, 1'b1, 1'b1, 1'b0);
        check_output("stall_hold_z", {15'b0, flag_z}, 16'h0001);
        apply_stimulus(4'd0, 16'h0001, 16'h0002, 4'd0, 4'd9, 1'b1, 1'b1, 1'b1);
        check_output("flush_valid", {15'b0, out_valid}, 16'h0000);
        apply_stimulus(4'd2, 16'h1234, 16'h1234, 4'd0, 4'd10, 1'b0, 1'b0, 1'b0);
        check_output("bubble_z", {15'b0, flag_z}, 16'h0001);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            apply_stimulus(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                           $urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0,
                           $urandom_range(0, 9) == 0);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
